// File: rtl/control_unit.sv
// control_unit: instruction-sequencing FSM for the RISC-SPM processor.
// Fetches, decodes and executes one 8-bit instruction at a time by steering
// the datapath load enables, PC controls, bus muxes and memory write strobe.
module control_unit #(
    parameter int word_size  = 8,
    parameter int op_size    = 4,
    parameter int state_size = 4,
    parameter int sel1_size  = 3,
    parameter int sel2_size  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic                 Load_R0,
    output logic                 Load_R1,
    output logic                 Load_R2,
    output logic                 Load_R3,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic [sel1_size-1:0] Sel_Bus_1_Mux,
    output logic [sel2_size-1:0] Sel_Bus_2_Mux,
    output logic                 Load_IR,
    output logic                 Load_Add_R,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic                 write,
    output logic                 halted
);

    typedef enum logic [state_size-1:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_t;

    localparam logic [op_size-1:0] OP_NOP = 4'd0;
    localparam logic [op_size-1:0] OP_ADD = 4'd1;
    localparam logic [op_size-1:0] OP_SUB = 4'd2;
    localparam logic [op_size-1:0] OP_AND = 4'd3;
    localparam logic [op_size-1:0] OP_NOT = 4'd4;
    localparam logic [op_size-1:0] OP_RD  = 4'd5;
    localparam logic [op_size-1:0] OP_WR  = 4'd6;
    localparam logic [op_size-1:0] OP_BR  = 4'd7;
    localparam logic [op_size-1:0] OP_BRZ = 4'd8;

    localparam logic [sel1_size-1:0] BUS1_PC  = 3'd4;
    localparam logic [sel2_size-1:0] BUS2_ALU = 2'd0;
    localparam logic [sel2_size-1:0] BUS2_B1  = 2'd1;
    localparam logic [sel2_size-1:0] BUS2_MEM = 2'd2;

    state_t             state;
    logic [op_size-1:0] opcode;
    logic [1:0]         src;
    logic [1:0]         dest;
    logic [3:0]         load_r;

    assign opcode = instruction[word_size-1 -: op_size];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    assign Load_R0 = load_r[0];
    assign Load_R1 = load_r[1];
    assign Load_R2 = load_r[2];
    assign Load_R3 = load_r[3];

    // State register: async reset to idle, otherwise step through the instruction phases
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_idle;
        end else begin
            case (state)
                S_idle: state <= S_fet1;
                S_fet1: state <= S_fet2;
                S_fet2: state <= S_dec;
                S_dec: begin
                    case (opcode)
                        OP_NOP:                 state <= S_fet1;
                        OP_ADD, OP_SUB, OP_AND: state <= S_ex1;
                        OP_NOT:                 state <= S_fet1;
                        OP_RD:                  state <= S_rd1;
                        OP_WR:                  state <= S_wr1;
                        OP_BR:                  state <= S_br1;
                        OP_BRZ:                 state <= zero ? S_br1 : S_fet1;
                        default:                state <= S_halt;
                    endcase
                end
                S_ex1:  state <= S_fet1;
                S_rd1:  state <= S_rd2;
                S_rd2:  state <= S_fet1;
                S_wr1:  state <= S_wr2;
                S_wr2:  state <= S_fet1;
                S_br1:  state <= S_br2;
                S_br2:  state <= S_fet1;
                S_halt: state <= S_halt;
                default: state <= S_idle;
            endcase
        end
    end

    // Datapath controls decoded from the current state (and opcode/zero while decoding)
    always_comb begin
        load_r        = 4'b0000;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Sel_Bus_1_Mux = '0;
        Sel_Bus_2_Mux = BUS2_ALU;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        write         = 1'b0;
        halted        = 1'b0;
        case (state)
            S_fet1: begin
                Sel_Bus_1_Mux = BUS1_PC;
                Sel_Bus_2_Mux = BUS2_B1;
                Load_Add_R    = 1'b1;
            end
            S_fet2: begin
                Sel_Bus_2_Mux = BUS2_MEM;
                Load_IR       = 1'b1;
                Inc_PC        = 1'b1;
            end
            S_dec: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus_1_Mux = sel1_size'(src);
                        Sel_Bus_2_Mux = BUS2_B1;
                        Load_Reg_Y    = 1'b1;
                    end
                    OP_NOT: begin
                        Sel_Bus_1_Mux = sel1_size'(src);
                        Sel_Bus_2_Mux = BUS2_ALU;
                        Load_Reg_Z    = 1'b1;
                        load_r[dest]  = 1'b1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        Sel_Bus_1_Mux = BUS1_PC;
                        Sel_Bus_2_Mux = BUS2_B1;
                        Load_Add_R    = 1'b1;
                    end
                    OP_BRZ: begin
                        if (zero) begin
                            Sel_Bus_1_Mux = BUS1_PC;
                            Sel_Bus_2_Mux = BUS2_B1;
                            Load_Add_R    = 1'b1;
                        end else begin
                            Inc_PC = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_ex1: begin
                Sel_Bus_1_Mux = sel1_size'(dest);
                Sel_Bus_2_Mux = BUS2_ALU;
                Load_Reg_Z    = 1'b1;
                load_r[dest]  = 1'b1;
            end
            S_rd1, S_wr1: begin
                Sel_Bus_2_Mux = BUS2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
            end
            S_rd2: begin
                Sel_Bus_2_Mux = BUS2_MEM;
                load_r[dest]  = 1'b1;
            end
            S_wr2: begin
                Sel_Bus_1_Mux = sel1_size'(src);
                write         = 1'b1;
            end
            S_br1: begin
                Sel_Bus_2_Mux = BUS2_MEM;
                Load_Add_R    = 1'b1;
            end
            S_br2: begin
                Sel_Bus_2_Mux = BUS2_MEM;
                Load_PC       = 1'b1;
            end
            S_halt: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for the RISC-SPM control unit.
// Expected per-cycle output vectors are queued when an instruction is applied
// and compared against the DUT outputs cycle by cycle.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [7:0] instruction;
    logic       zero;
    logic       Load_R0, Load_R1, Load_R2, Load_R3;
    logic       Load_PC, Inc_PC;
    logic [2:0] Sel_Bus_1_Mux;
    logic [1:0] Sel_Bus_2_Mux;
    logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
    logic       write, halted;

    logic [16:0] obs;
    logic [16:0] expQ[$];
    string       tagQ[$];
    int          checks = 0;
    int          errors = 0;

    control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .zero          (zero),
        .Load_R0       (Load_R0),
        .Load_R1       (Load_R1),
        .Load_R2       (Load_R2),
        .Load_R3       (Load_R3),
        .Load_PC       (Load_PC),
        .Inc_PC        (Inc_PC),
        .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
        .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
        .Load_IR       (Load_IR),
        .Load_Add_R    (Load_Add_R),
        .Load_Reg_Y    (Load_Reg_Y),
        .Load_Reg_Z    (Load_Reg_Z),
        .write         (write),
        .halted        (halted)
    );

    assign obs = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC,
                  Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
                  Load_Reg_Y, Load_Reg_Z, write, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pack one expected output vector in the same order as obs
    function automatic logic [16:0] mk(input logic [3:0] lr, input logic lpc, input logic ipc,
                                       input logic [2:0] s1, input logic [1:0] s2,
                                       input logic lir, input logic lar, input logic ly,
                                       input logic lz, input logic wr, input logic hl);
        return {lr, lpc, ipc, s1, s2, lir, lar, ly, lz, wr, hl};
    endfunction

    task automatic checkOutput(input string tag, input logic [16:0] got, input logic [16:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic pushExp(input string tag, input logic [16:0] v);
        tagQ.push_back(tag);
        expQ.push_back(v);
    endtask

    // Drive an instruction and queue the cycle-by-cycle outputs it should produce
    task automatic applyStimulus(input logic [7:0] instr, input logic z, input string name);
        logic [3:0] op;
        logic [1:0] s;
        logic [1:0] d;
        logic [16:0] fetchAddr;
        op = instr[7:4];
        s  = instr[3:2];
        d  = instr[1:0];
        instruction = instr;
        zero        = z;
        fetchAddr = mk(4'b0, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
        pushExp({name, "_fet1"}, fetchAddr);
        pushExp({name, "_fet2"}, mk(4'b0, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0));
        case (op)
            4'd0: pushExp({name, "_dec"}, 17'd0);
            4'd1, 4'd2, 4'd3: begin
                pushExp({name, "_dec"}, mk(4'b0, 0, 0, {1'b0, s}, 2'd1, 0, 0, 1, 0, 0, 0));
                pushExp({name, "_ex1"}, mk(4'b1 << d, 0, 0, {1'b0, d}, 2'd0, 0, 0, 0, 1, 0, 0));
            end
            4'd4: pushExp({name, "_dec"}, mk(4'b1 << d, 0, 0, {1'b0, s}, 2'd0, 0, 0, 0, 1, 0, 0));
            4'd5: begin
                pushExp({name, "_dec"}, fetchAddr);
                pushExp({name, "_rd1"}, mk(4'b0, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
                pushExp({name, "_rd2"}, mk(4'b1 << d, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));
            end
            4'd6: begin
                pushExp({name, "_dec"}, fetchAddr);
                pushExp({name, "_wr1"}, mk(4'b0, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
                pushExp({name, "_wr2"}, mk(4'b0, 0, 0, {1'b0, s}, 2'd0, 0, 0, 0, 0, 1, 0));
            end
            4'd7, 4'd8: begin
                if (op == 4'd8 && !z) begin
                    pushExp({name, "_dec"}, mk(4'b0, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0));
                end else begin
                    pushExp({name, "_dec"}, fetchAddr);
                    pushExp({name, "_br1"}, mk(4'b0, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
                    pushExp({name, "_br2"}, mk(4'b0, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));
                end
            end
            default: begin
                pushExp({name, "_dec"}, 17'd0);
                for (int i = 0; i < 12; i++)
                    pushExp({name, "_halt"}, mk(4'b0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1));
            end
        endcase
    endtask

    // Compare up to n queued vectors, one per clock, sampling at the falling edge
    task automatic drain(input int n);
        int k;
        k = 0;
        while (expQ.size() > 0 && k < n) begin
            @(negedge clk);
            checkOutput(tagQ.pop_front(), obs, expQ.pop_front());
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    // Assert reset between edges, check outputs clear at once, then release so fet1 follows
    task automatic doReset(input string name);
        #2;
        rst = 1'b0;
        #1;
        checkOutput({name, "_async"}, obs, 17'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput({name, "_hold"}, obs, 17'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rop;
        logic [3:0] rlo;
        logic       rz;
        rst         = 1'b1;
        instruction = 8'h00;
        zero        = 1'b0;
        #3;
        doReset("reset_init");

        applyStimulus(8'h16, 1'b0, "ADD_R1_R2");  drain(100);
        applyStimulus(8'h53, 1'b0, "RD_R3");      drain(100);
        applyStimulus(8'h64, 1'b1, "WR_R1");      drain(100);
        applyStimulus(8'h80, 1'b0, "BRZ_nt");     drain(100);
        applyStimulus(8'h80, 1'b1, "BRZ_t");      drain(100);
        applyStimulus(8'h41, 1'b1, "NOT_R0_R1");  drain(100);
        applyStimulus(8'h00, 1'b1, "NOP");        drain(100);
        applyStimulus(8'h2E, 1'b1, "SUB_R3_R2");  drain(100);
        applyStimulus(8'h3B, 1'b0, "AND_R2_R3");  drain(100);
        applyStimulus(8'h70, 1'b0, "BR");         drain(100);
        applyStimulus(8'h4F, 1'b0, "NOT_R3_R3");  drain(100);

        for (int i = 0; i < 20; i++) begin
            rop = 4'($urandom_range(0, 8));
            rlo = 4'($urandom_range(0, 15));
            rz  = 1'($urandom_range(0, 1));
            applyStimulus({rop, rlo}, rz, "RAND");
            drain(100);
        end

        // Abort an instruction in S_dec with an asynchronous reset
        applyStimulus(8'h2D, 1'b0, "SUB_abort");
        drain(2);
        expQ.delete();
        tagQ.delete();
        doReset("reset_mid");
        applyStimulus(8'h16, 1'b0, "ADD_after_reset");  drain(100);

        // Illegal opcode halts until reset
        applyStimulus(8'hF0, 1'b0, "ILL_F0");  drain(100);
        doReset("reset_halt");
        applyStimulus(8'h9A, 1'b1, "ILL_9A");  drain(100);
        doReset("reset_halt2");
        applyStimulus(8'h00, 1'b0, "NOP_final");  drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing FSM for the RISC-SPM processor. It fetches, decodes and executes one 8-bit instruction at a time. It does this by driving the register load enables, the PC controls, the Bus_1 source select, the Bus_2 three-channel mux select (ALU / Bus_1 / memory) and the memory write strobe. It sits beside the datapath and consumes only the IR contents and the ALU zero flag.

## Interface
- word_size, 8: instruction width; opcode = instruction[7:4], src = [3:2], dest = [1:0]
- op_size, 4: opcode field width
- state_size, 4: state register width
- sel1_size, 3: Bus_1 select width
- sel2_size, 2: Bus_2 select width

- clk  in  1  single clock; state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- instruction  in  word_size  IR contents
- zero  in  1  Reg_Z zero flag from ALU
- Load_R0, Load_R1, Load_R2, Load_R3  out  1 each  register load enables
- Load_PC  out  1  load PC from Bus_2
- Inc_PC  out  1  PC <= PC+1
- Sel_Bus_1_Mux  out  sel1_size  0..3 = R0..R3, 4 = PC
- Sel_Bus_2_Mux  out  sel2_size  0 = alu_out, 1 = Bus_1, 2 = mem_word
- Load_IR  out  1  IR <= Bus_2
- Load_Add_R  out  1  address register <= Bus_2
- Load_Reg_Y  out  1  Y <= Bus_2
- Load_Reg_Z  out  1  Z flag <= ALU zero
- write  out  1  memory[Add_R] <= Bus_1
- halted  out  1  high in S_halt

## Operation
- States (binary 0..11): S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Codes 9..15 are illegal.
- Output defaults: every output is 0 (Sel_Bus_1_Mux=0, Sel_Bus_2_Mux=0) unless a state asserts it.
- "src sel" means Sel_Bus_1_Mux=src. "load dest" means Load_R[dest]=1.
- "Fetch addr" means Sel_Bus_1_Mux=4, Sel_Bus_2_Mux=1, Load_Add_R.

State actions and transitions:
- S_idle: no outputs; -> S_fet1.
- S_fet1: fetch addr; -> S_fet2.
- S_fet2: Sel_Bus_2_Mux=2, Load_IR, Inc_PC; -> S_dec.
- S_dec, by opcode:
  - NOP: no outputs; -> S_fet1.
  - ADD/SUB/AND: src sel, Sel_Bus_2_Mux=1, Load_Reg_Y; -> S_ex1.
  - NOT: src sel, Sel_Bus_2_Mux=0, Load_Reg_Z, load dest; -> S_fet1.
  - RD: fetch addr; -> S_rd1.
  - WR: fetch addr; -> S_wr1.
  - BR: fetch addr; -> S_br1.
  - BRZ, zero=1: fetch addr; -> S_br1.
  - BRZ, zero=0: Inc_PC only; -> S_fet1 (skips the address word).
  - Illegal: no outputs; -> S_halt.
- S_ex1: Sel_Bus_1_Mux=dest, Sel_Bus_2_Mux=0, Load_Reg_Z, load dest; -> S_fet1.
- S_rd1 / S_wr1: Sel_Bus_2_Mux=2, Load_Add_R, Inc_PC; -> S_rd2 / S_wr2.
- S_rd2: Sel_Bus_2_Mux=2, load dest; -> S_fet1.
- S_wr2: src sel, write; -> S_fet1.
- S_br1: Sel_Bus_2_Mux=2, Load_Add_R; -> S_br2.
- S_br2: Sel_Bus_2_Mux=2, Load_PC; -> S_fet1.
- S_halt: halted=1, no other outputs; self-loop until rst.
- At most one Load_Rn is asserted per cycle.
- write and Load_PC are never asserted in the same cycle.

## Timing
- State register: rst=0 forces S_idle immediately, regardless of clk. Otherwise the state updates on posedge clk.
- Outputs are combinational from state; in S_dec they also depend on instruction and zero. No output is registered.
- Reset values: every output is 0, including halted.
- First S_fet1 is the first posedge after rst deasserts.
- instruction is stable throughout S_dec..end of instruction, because Load_IR is asserted only in S_fet2.
- zero is sampled only in S_dec.
- Cycles per instruction, fet1 through the last state:
  - NOP 3
  - NOT 3
  - ADD/SUB/AND 4
  - BRZ not taken 3
  - RD/WR/BR 5
  - BRZ taken 5
- Reset asserted mid-instruction aborts it immediately (state -> S_idle, all outputs 0). Partial PC/register updates are not undone.

## Test plan
- Reset: rst=0 at an arbitrary state -> state S_idle asynchronously, all outputs 0. After release, S_fet1 next edge with Sel_Bus_1_Mux=4, Sel_Bus_2_Mux=1, Load_Add_R=1.
- ADD R1,R2 (instruction=8'h16): S_dec shows Sel_Bus_1_Mux=1, Load_Reg_Y=1. S_ex1 shows Sel_Bus_1_Mux=2, Sel_Bus_2_Mux=0, Load_R2=1, Load_Reg_Z=1. Back in S_fet1 after 4 cycles.
- RD R3 (8'h53): S_rd1 shows Inc_PC=1, Load_Add_R=1, Sel_Bus_2_Mux=2. S_rd2 shows Load_R3=1, Sel_Bus_2_Mux=2. WR src R1 (8'h64): S_wr2 shows write=1, Sel_Bus_1_Mux=1.
- BRZ (8'h80), zero=0: S_dec shows Inc_PC=1 only, then S_fet1. BRZ with zero=1: S_br1 then S_br2 with Load_PC=1, Sel_Bus_2_Mux=2.
- Illegal opcode 8'hF0: S_dec -> S_halt. halted=1 and all other outputs 0 for 10+ cycles, cleared only by rst=0.
- NOT R0->R1 (8'h41): S_dec shows Sel_Bus_1_Mux=0, Sel_Bus_2_Mux=0, Load_R1=1, Load_Reg_Z=1, then S_fet1 (3 cycles).
